// File: rtl/czono_intersect_seq.sv
// czono_intersect_seq: streams the appended constraint rows of an
// R-generalised constrained-zonotope intersection, one MAC per cycle.
// Define CZI_SATURATE_EN to clamp reduced results instead of wrapping.
module czono_intersect_seq #(
    parameter int NMAX       = 3,
    parameter int NGMAX      = 15,
    parameter int NRMAX      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rstn_i,
    input  logic                                 start_i,
    input  logic [$clog2(NMAX):0]                z_n_i,
    input  logic [$clog2(NGMAX):0]               z_ng_i,
    input  logic [$clog2(NRMAX):0]               y_n_i,
    input  logic [$clog2(NGMAX):0]               y_ng_i,
    input  logic [$clog2(NRMAX):0]               r_nr_i,
    input  logic [NRMAX*NMAX*DATA_WIDTH-1:0]     r_i,
    input  logic [NMAX*DATA_WIDTH-1:0]           zc_i,
    input  logic [NMAX*NGMAX*DATA_WIDTH-1:0]     zg_i,
    input  logic [NRMAX*DATA_WIDTH-1:0]          yc_i,
    input  logic [NRMAX*NGMAX*DATA_WIDTH-1:0]    yg_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 err_o,
    output logic                                 row_valid_o,
    input  logic                                 row_ready_i,
    output logic [$clog2(NRMAX)-1:0]             row_idx_o,
    output logic [NGMAX*DATA_WIDTH-1:0]          a_row_o,
    output logic [DATA_WIDTH-1:0]                b_o
);

    localparam int DW   = DATA_WIDTH;
    localparam int ZNW  = $clog2(NMAX) + 1;
    localparam int GNW  = $clog2(NGMAX) + 1;
    localparam int RNW  = $clog2(NRMAX) + 1;
    localparam int IW   = $clog2(NRMAX);
    localparam int KIW  = $clog2(NGMAX);
    localparam int PW   = 2 * DW;
    localparam int ACCW = PW + $clog2(NMAX) + 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MAC_C,
        MAC_G,
        EMIT,
        DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [ZNW-1:0]             zn_q, zn_d;
    logic [GNW-1:0]             zng_q, zng_d;
    logic [RNW-1:0]             yn_q, yn_d;
    logic [GNW-1:0]             yng_q, yng_d;
    logic [RNW-1:0]             rnr_q, rnr_d;
    logic                       err_q, err_d;
    logic [IW-1:0]              i_q, i_d;
    logic [ZNW-1:0]             j_q, j_d;
    logic [GNW-1:0]             k_q, k_d;
    logic signed [ACCW-1:0]     acc_q, acc_d;
    logic [NGMAX-1:0][DW-1:0]   a_q, a_d;
    logic [DW-1:0]              b_q, b_d;

    logic [DW-1:0]              op_r;
    logic [DW-1:0]              op_x;
    logic [DW-1:0]              yc_w;
    logic signed [PW-1:0]       ext_r;
    logic signed [PW-1:0]       ext_x;
    logic signed [PW-1:0]       prod;
    logic signed [ACCW-1:0]     sum;
    logic [IW-1:0]              nrow;
    logic [NGMAX-1:0][DW-1:0]   a_init;
    logic                       bad;
    logic                       last_j;
    logic                       last_k;
    logic                       last_i;

    function automatic logic signed [ACCW-1:0] sext(input logic [DW-1:0] w);
        return {{(ACCW-DW){w[DW-1]}}, w};
    endfunction

    // Reduce a wide value to one data word: clamp or wrap.
    function automatic logic [DW-1:0] clip(input logic signed [ACCW-1:0] s);
        logic [DW-1:0] r;
        r = s[DW-1:0];
`ifdef CZI_SATURATE_EN
        if (s[ACCW-1:DW-1] != {(ACCW-DW+1){s[ACCW-1]}})
            r = s[ACCW-1] ? {1'b1, {(DW-1){1'b0}}}
                          : {1'b0, {(DW-1){1'b1}}};
`endif
        return r;
    endfunction

    function automatic logic [DW-1:0] reduce(input logic signed [ACCW-1:0] v);
        logic signed [ACCW-1:0] s;
        s = v >>> FRAC_BITS;
        return clip(s);
    endfunction

    function automatic logic [DW-1:0] neg(input logic [DW-1:0] w);
        logic signed [ACCW-1:0] s;
        s = -sext(w);
        return clip(s);
    endfunction

    // Operand fetch and the single signed multiply-accumulate.
    always_comb begin
        op_r  = r_i[(int'(i_q) * NMAX + int'(j_q)) * DW +: DW];
        op_x  = zc_i[int'(j_q) * DW +: DW];
        if (state_q == MAC_G)
            op_x = zg_i[(int'(j_q) * NGMAX + int'(k_q)) * DW +: DW];
        yc_w  = yc_i[int'(i_q) * DW +: DW];
        ext_r = {{DW{op_r[DW-1]}}, op_r};
        ext_x = {{DW{op_x[DW-1]}}, op_x};
        prod  = ext_r * ext_x;
        sum   = acc_q + {{(ACCW-PW){prod[PW-1]}}, prod};
    end

    // Fresh row image: zeros plus the negated Y.G row after the Z part.
    always_comb begin
        nrow   = (state_q == EMIT) ? i_q + IW'(1) : '0;
        a_init = '0;
        for (int p = 0; p < NGMAX; p++) begin
            if (p >= int'(zng_q) && p < int'(zng_q) + int'(yng_q))
                a_init[p] = neg(yg_i[(int'(nrow) * NGMAX + p
                                     - int'(zng_q)) * DW +: DW]);
        end
    end

    // Size legality and loop-end flags.
    always_comb begin
        bad = (rnr_q == '0) || (yn_q != rnr_q) || (zn_q == '0)
           || (int'(zn_q) > NMAX) || (int'(rnr_q) > NRMAX)
           || (int'(zng_q) + int'(yng_q) > NGMAX);
        last_j = (j_q == zn_q - ZNW'(1));
        last_k = (k_q == zng_q - GNW'(1));
        last_i = ({1'b0, i_q} == rnr_q - RNW'(1));
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        zn_d    = zn_q;
        zng_d   = zng_q;
        yn_d    = yn_q;
        yng_d   = yng_q;
        rnr_d   = rnr_q;
        err_d   = err_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    zn_d    = z_n_i;
                    zng_d   = z_ng_i;
                    yn_d    = y_n_i;
                    yng_d   = y_ng_i;
                    rnr_d   = r_nr_i;
                    err_d   = 1'b0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (bad) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    a_d     = a_init;
                    j_d     = '0;
                    acc_d   = '0;
                    state_d = MAC_C;
                end
            end
            MAC_C: begin
                if (last_j) begin
                    b_d   = clip(sext(yc_w) - sext(reduce(sum)));
                    acc_d = '0;
                    j_d   = '0;
                    k_d   = '0;
                    state_d = (zng_q == '0) ? EMIT : MAC_G;
                end else begin
                    acc_d = sum;
                    j_d   = j_q + ZNW'(1);
                end
            end
            MAC_G: begin
                if (last_j) begin
                    a_d[k_q[KIW-1:0]] = reduce(sum);
                    acc_d = '0;
                    j_d   = '0;
                    if (last_k)
                        state_d = EMIT;
                    else
                        k_d = k_q + GNW'(1);
                end else begin
                    acc_d = sum;
                    j_d   = j_q + ZNW'(1);
                end
            end
            EMIT: begin
                if (row_ready_i) begin
                    if (last_i) begin
                        state_d = DONE;
                    end else begin
                        i_d     = nrow;
                        a_d     = a_init;
                        j_d     = '0;
                        acc_d   = '0;
                        state_d = MAC_C;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Latched sizes, counters, accumulator and row outputs.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            zn_q  <= '0;
            zng_q <= '0;
            yn_q  <= '0;
            yng_q <= '0;
            rnr_q <= '0;
            err_q <= 1'b0;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            zn_q  <= zn_d;
            zng_q <= zng_d;
            yn_q  <= yn_d;
            yng_q <= yng_d;
            rnr_q <= rnr_d;
            err_q <= err_d;
            i_q   <= i_d;
            j_q   <= j_d;
            k_q   <= k_d;
            acc_q <= acc_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign err_o       = (state_q == DONE) && err_q;
    assign row_valid_o = (state_q == EMIT);
    assign row_idx_o   = i_q;
    assign a_row_o     = a_q;
    assign b_o         = b_q;

endmodule

// File: tb/tb_czono_intersect_seq.sv
// tb_czono_intersect_seq: directed Q16.16 vectors and sequences
// for the constraint-row generator.
`timescale 1ns/1ps
module tb_czono_intersect_seq;

    localparam int NMAX  = 3;
    localparam int NGMAX = 15;
    localparam int NRMAX = 16;
    localparam int DW    = 32;
    localparam int AW    = NGMAX * DW;
    localparam logic [31:0] ONE = 32'h0001_0000;
`ifdef CZI_SATURATE_EN
    localparam logic [31:0] B_OVF   = 32'h8000_0001;
    localparam logic [31:0] NEG_MIN = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] B_OVF   = 32'hFFFF_0000;
    localparam logic [31:0] NEG_MIN = 32'h8000_0000;
`endif

    typedef logic [AW-1:0] aw_t;

    typedef struct {
        logic [2:0]  zn;
        logic [4:0]  zng;
        logic [4:0]  yng;
        logic [31:0] r0, r1, c0, c1;
        logic [31:0] g00, g01, g10, g11;
        logic [31:0] yc, yg;
        logic [31:0] eb, ea0, ea1, ea2;
    } vec_t;

    typedef struct {
        logic [2:0] zn;
        logic [4:0] zng, yn, yng, rnr;
    } ev_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic row_ready = 1'b0;
    logic [2:0] z_n = '0;
    logic [4:0] z_ng = '0, y_n = '0, y_ng = '0, r_nr = '0;
    logic [NRMAX*NMAX-1:0][DW-1:0]  r;
    logic [NMAX-1:0][DW-1:0]        zc;
    logic [NMAX*NGMAX-1:0][DW-1:0]  zg;
    logic [NRMAX-1:0][DW-1:0]       yc;
    logic [NRMAX*NGMAX-1:0][DW-1:0] yg;
    logic busy, done, err, row_valid;
    logic [3:0] row_idx;
    logic [AW-1:0] a_row;
    logic [DW-1:0] b;

    int n_chk = 0;
    int n_fail = 0;

    vec_t vt[7];
    ev_t  et[6];

    czono_intersect_seq dut (
        .clk_i(clk), .rstn_i(rstn), .start_i(start),
        .z_n_i(z_n), .z_ng_i(z_ng), .y_n_i(y_n),
        .y_ng_i(y_ng), .r_nr_i(r_nr),
        .r_i(r), .zc_i(zc), .zg_i(zg), .yc_i(yc), .yg_i(yg),
        .busy_o(busy), .done_o(done), .err_o(err),
        .row_valid_o(row_valid), .row_ready_i(row_ready),
        .row_idx_o(row_idx), .a_row_o(a_row), .b_o(b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input aw_t act, input aw_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic aw_t mk3(input logic [31:0] a0, a1, a2);
        aw_t v;
        v = '0;
        v[31:0]  = a0;
        v[63:32] = a1;
        v[95:64] = a2;
        return v;
    endfunction

    task automatic clr();
        r = '0; zc = '0; zg = '0; yc = '0; yg = '0;
    endtask

    task automatic pulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_valid(input int maxc, output int cyc);
        cyc = 0;
        while (!row_valid && cyc < maxc) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic ack();
        row_ready = 1'b1;
        @(negedge clk);
        row_ready = 1'b0;
    endtask

    task automatic setup_i2();
        clr();
        z_n = 3'd2; z_ng = 5'd2; y_n = 5'd2; y_ng = 5'd1; r_nr = 5'd2;
        r[0] = ONE; r[4] = ONE;
        zc[0] = ONE; zc[1] = 32'h0002_0000;
        zg[0] = ONE; zg[16] = ONE;
        yc[0] = 32'h0003_0000; yc[1] = 32'h0005_0000;
        yg[0] = ONE; yg[15] = ONE;
    endtask

    task automatic run_i2(input bit do_st, input bit hold, input bit dup);
        int cyc;
        int pre;
        aw_t ea0, ea1;
        ea0 = mk3(ONE, 32'h0, 32'hFFFF_0000);
        ea1 = mk3(32'h0, ONE, 32'hFFFF_0000);
        if (do_st) pulse();
        wait_valid(40, cyc);
        chk("i2_lat0", aw_t'(cyc), aw_t'(7));
        chk("i2_a0", a_row, ea0);
        chk("i2_b0", aw_t'(b), aw_t'(32'h0002_0000));
        chk("i2_idx0", aw_t'(row_idx), aw_t'(0));
        if (hold) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                chk("hold_valid", aw_t'(row_valid), aw_t'(1'b1));
                chk("hold_a", a_row, ea0);
                chk("hold_b", aw_t'(b), aw_t'(32'h0002_0000));
            end
        end
        ack();
        pre = 0;
        if (dup) begin
            start = 1'b1; r_nr = 5'd1;
            @(negedge clk);
            start = 1'b0; r_nr = 5'd2;
            pre = 1;
        end
        wait_valid(40, cyc);
        chk("i2_lat1", aw_t'(cyc + pre), aw_t'(6));
        chk("i2_a1", a_row, ea1);
        chk("i2_b1", aw_t'(b), aw_t'(32'h0003_0000));
        chk("i2_idx1", aw_t'(row_idx), aw_t'(1));
        ack();
        chk("i2_done", aw_t'(done), aw_t'(1'b1));
        chk("i2_err", aw_t'(err), aw_t'(1'b0));
        @(negedge clk);
        chk("i2_idle_busy", aw_t'(busy), aw_t'(1'b0));
        chk("i2_idle_done", aw_t'(done), aw_t'(1'b0));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, aw_t'(busy), aw_t'(1'b0));
        chk({nm, "_done"}, aw_t'(done), aw_t'(1'b0));
        chk({nm, "_err"}, aw_t'(err), aw_t'(1'b0));
        chk({nm, "_valid"}, aw_t'(row_valid), aw_t'(1'b0));
        chk({nm, "_idx"}, aw_t'(row_idx), aw_t'(0));
        chk({nm, "_a"}, a_row, aw_t'(0));
        chk({nm, "_b"}, aw_t'(b), aw_t'(0));
    endtask

    initial begin
        int cyc;
        int lat;
        bit seen, e, v;

        vt[0] = '{3'd2, 5'd2, 5'd1, ONE, 32'h0002_0000,
                  32'h0003_0000, 32'hFFFF_0000,
                  ONE, 32'h0, 32'h0, ONE,
                  32'h0005_0000, 32'h0000_8000,
                  32'h0004_0000, ONE, 32'h0002_0000, 32'hFFFF_8000};
        vt[1] = '{3'd1, 5'd1, 5'd1, 32'h0000_8000, 32'h0,
                  32'h0003_0000, 32'h0,
                  32'hFFFE_0000, 32'h0, 32'h0, 32'h0,
                  32'h0, 32'hFFFF_0000,
                  32'hFFFE_8000, 32'hFFFF_0000, ONE, 32'h0};
        vt[2] = '{3'd1, 5'd1, 5'd0, 32'h0000_0001, 32'h0,
                  32'h0000_8000, 32'h0,
                  32'hFFFF_8000, 32'h0, 32'h0, 32'h0,
                  ONE, 32'h0,
                  ONE, 32'hFFFF_FFFF, 32'h0, 32'h0};
        vt[3] = '{3'd2, 5'd0, 5'd1, 32'h0002_0000, 32'h0003_0000,
                  ONE, ONE,
                  32'h0, 32'h0, 32'h0, 32'h0,
                  ONE, 32'h0000_4000,
                  32'hFFFC_0000, 32'hFFFF_C000, 32'h0, 32'h0};
        vt[4] = '{3'd1, 5'd1, 5'd1, ONE, 32'h0,
                  32'h0, 32'h0,
                  ONE, 32'h0, 32'h0, 32'h0,
                  32'h0, 32'h8000_0000,
                  32'h0, ONE, NEG_MIN, 32'h0};
        vt[5] = '{3'd2, 5'd2, 5'd0, ONE, 32'hFFFF_0000,
                  32'h0, 32'h0,
                  32'h0002_0000, ONE, 32'h0003_0000, 32'h0000_8000,
                  32'hFFFE_0000, 32'h0,
                  32'hFFFE_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0};
        vt[6] = '{3'd1, 5'd0, 5'd0, 32'h7FFF_0000, 32'h0,
                  32'h7FFF_0000, 32'h0,
                  32'h0, 32'h0, 32'h0, 32'h0,
                  32'h0, 32'h0,
                  B_OVF, 32'h0, 32'h0, 32'h0};

        et[0] = '{3'd2, 5'd2, 5'd3, 5'd1, 5'd2};
        et[1] = '{3'd0, 5'd1, 5'd1, 5'd1, 5'd1};
        et[2] = '{3'd4, 5'd1, 5'd1, 5'd1, 5'd1};
        et[3] = '{3'd1, 5'd10, 5'd1, 5'd6, 5'd1};
        et[4] = '{3'd1, 5'd1, 5'd0, 5'd1, 5'd0};
        et[5] = '{3'd1, 5'd1, 5'd17, 5'd1, 5'd17};

        clr();
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rstn = 1'b1;

        setup_i2();
        run_i2(1'b1, 1'b1, 1'b1);

        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            clr();
            z_n = vt[t].zn; z_ng = vt[t].zng; y_ng = vt[t].yng;
            y_n = 5'd1; r_nr = 5'd1;
            r[0] = vt[t].r0; r[1] = vt[t].r1;
            zc[0] = vt[t].c0; zc[1] = vt[t].c1;
            zg[0] = vt[t].g00; zg[1] = vt[t].g01;
            zg[15] = vt[t].g10; zg[16] = vt[t].g11;
            yc[0] = vt[t].yc; yg[0] = vt[t].yg;
            lat = 1 + int'(vt[t].zn) * (1 + int'(vt[t].zng));
            pulse();
            wait_valid(60, cyc);
            chk($sformatf("v%0d_lat", t), aw_t'(cyc), aw_t'(lat));
            chk($sformatf("v%0d_a", t), a_row,
                mk3(vt[t].ea0, vt[t].ea1, vt[t].ea2));
            chk($sformatf("v%0d_b", t), aw_t'(b), aw_t'(vt[t].eb));
            chk($sformatf("v%0d_idx", t), aw_t'(row_idx), aw_t'(0));
            ack();
            chk($sformatf("v%0d_done", t), aw_t'(done), aw_t'(1'b1));
            chk($sformatf("v%0d_err", t), aw_t'(err), aw_t'(1'b0));
        end

        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            clr();
            z_n = et[t].zn; z_ng = et[t].zng; y_n = et[t].yn;
            y_ng = et[t].yng; r_nr = et[t].rnr;
            pulse();
            seen = 1'b0; e = 1'b0; v = 1'b0;
            for (int c = 0; c < 3 && !seen; c++) begin
                if (row_valid) v = 1'b1;
                if (done) begin
                    seen = 1'b1;
                    e = err;
                end else begin
                    @(negedge clk);
                end
            end
            chk($sformatf("e%0d_done", t), aw_t'(seen), aw_t'(1'b1));
            chk($sformatf("e%0d_err", t), aw_t'(e), aw_t'(1'b1));
            chk($sformatf("e%0d_novalid", t), aw_t'(v), aw_t'(1'b0));
        end

        @(negedge clk);
        setup_i2();
        pulse();
        wait_valid(40, cyc);
        ack();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk_zero("abort");
        @(negedge clk);
        chk("abort_nodone", aw_t'(done), aw_t'(1'b0));
        rstn = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_i2(1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/czono_intersect_seq.md
CZONO_INTERSECT_SEQ -- requirements
Module: czono_intersect_seq

Interface
REQ-001 SHALL have parameter NMAX, default 3: maximum state dimension of Z (columns of R).
REQ-002 SHALL have parameter NGMAX, default 15: maximum generator count of Z and of the output; Y generators share this budget.
REQ-003 SHALL have parameter NRMAX, default 16: maximum rows of R (dimension of Y).
REQ-004 SHALL have parameter DATA_WIDTH, default 32: signed fixed-point word width.
REQ-005 SHALL have parameter FRAC_BITS, default 16: fractional bits of every word.
REQ-006 SHALL have clk_i, input, 1: single clock, rising edge.
REQ-007 SHALL have rstn_i, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have start_i, input, 1: launch; sizes latched on accept.
REQ-009 SHALL have z_n_i, z_ng_i, y_n_i, y_ng_i, r_nr_i, inputs, $clog2(max)+1 each: operand sizes.
REQ-010 SHALL have r_i, zc_i, zg_i, yc_i, yg_i, inputs, flattened row-major DATA_WIDTH words: R, Z.c, Z.G, Y.c, Y.G, held stable while busy_o.
REQ-011 SHALL have busy_o, done_o and err_o, outputs, 1 bit each: busy flag, one-cycle completion pulse, and size-error flag valid with done_o.
REQ-012 SHALL have row_valid_o (output, 1), row_ready_i (input, 1), row_idx_o (output, $clog2(NRMAX)), a_row_o (output, NGMAX*DATA_WIDTH) and b_o (output, DATA_WIDTH): new-constraint row stream.

Function
REQ-013 SHALL compute, per row i < r_nr, the appended constraint row of R-generalised intersection: a_row = [R[i]*Z.G, -Y.G[i], zeros], b = Y.c[i] - R[i]*Z.c.
REQ-014 SHALL use states IDLE, CHECK, MAC_C, MAC_G, EMIT, DONE; IDLE->CHECK on start_i; CHECK->DONE on error, else MAC_C; MAC_C->MAC_G after z_n cycles; MAC_G->EMIT after z_n*z_ng cycles; EMIT->MAC_C (next row) or DONE on handshake; DONE->IDLE after one cycle.
REQ-015 SHALL use one multiply-accumulator, one product per cycle; per-row compute latency z_n*(1+z_ng) cycles.
REQ-016 SHALL form products at 2*DATA_WIDTH bits, accumulate at 2*DATA_WIDTH+$clog2(NMAX)+1 bits, then arithmetic-shift right by FRAC_BITS (floor) and reduce to DATA_WIDTH per REQ-026/027.
REQ-017 SHALL compute b and -Y.G negation in two's complement; negating the most-negative value follows the same reduction rule.
REQ-018 SHALL hold row_valid_o high in EMIT with a_row_o, b_o, row_idx_o stable until row_ready_i is high on a rising edge; row_ready_i outside EMIT is ignored.
REQ-019 SHALL flag err_o (and emit no rows) when r_nr=0, y_n != r_nr, z_n=0, z_n>NMAX, r_nr>NRMAX, or z_ng+y_ng>NGMAX.
REQ-020 SHALL ignore start_i while busy_o is high; busy_o is high in every state except IDLE.
REQ-021 SHALL hold a_row_o words with index >= z_ng+y_ng at zero.
REQ-022 SHALL handle z_ng=0 by skipping MAC_G (MAC_C->EMIT).

Reset
REQ-023 SHALL, when rstn_i is low at a rising edge, enter IDLE and drive busy_o, done_o, err_o, row_valid_o, row_idx_o, a_row_o, b_o to zero, clear accumulators and counters.
REQ-024 SHALL abort an in-flight operation on reset without emitting further rows or done_o.
REQ-025 SHALL accept start_i on the first edge after rstn_i returns high.

Configuration
REQ-026 SHALL, with CZI_SATURATE_EN defined, clamp every reduced result to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-027 SHALL, without CZI_SATURATE_EN, truncate (wrap) to the low DATA_WIDTH bits.

Verification
REQ-028 SHALL cover: R=I2, Z.c=[1,2], Z.G=I2, Y.c=[3,5], Y.G=[[1],[1]] (Q16.16) -> rows 0:[1,0,-1] b=2, 1:[0,1,-1] b=3; done_o after 2 rows.
REQ-029 SHALL cover: row_ready_i held low 10 cycles in EMIT -> row_valid_o, a_row_o, b_o unchanged throughout.
REQ-030 SHALL cover: y_n=3, r_nr=2 -> done_o with err_o=1 within 3 cycles of start, no row_valid_o.
REQ-031 SHALL cover: R=[[32767.0]], Z.c=[32767.0], Y.c=[0] -> b=0x80000001 with CZI_SATURATE_EN, wrapped value without.
REQ-032 SHALL cover: rstn_i low during MAC_G of row 1 -> all outputs zero next edge, no done_o; fresh start completes correctly.
REQ-033 SHALL cover: start_i pulsed while busy -> ignored, result identical to single-start run.
